// File: rtl/dcache_pkg.sv
// Shared types for the direct-mapped data cache controller.
//   - Load/store mask encodings used on the core side.
//   - Controller FSM state encoding.
//   - Per-line state record.
package dcache_pkg;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StAllocate
    } state_e;

    // The tag field holds the full word address addr[31:2] of the cached line. The index bits
    // inside it always equal the line's own index, so comparing the whole field is the same as
    // a tag compare, and the victim address is simply {tag, 2'b00}. This keeps the struct
    // independent of the LINES parameter.
    typedef struct packed {
        logic        valid;
        logic        dirty;
        logic [29:0] tag;
        logic [31:0] data;
    } line_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational load extraction and store merging for one 32-bit word.
// Ports:
//   word_i       current word (line data)
//   offset_i     byte offset, addr[1:0]
//   mask_i       access size/sign encoding (MASK_*)
//   store_data_i store data; byte/half taken from the low bits
//   load_data_o  extended load result; 0 for an unknown mask
//   store_word_o word_i with the store lane(s) replaced
module load_store_align
    import dcache_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  mask_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

        case (mask_i)
            MASK_B:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
            MASK_H:  load_data_o = {{16{half_sel[15]}}, half_sel};
            MASK_W:  load_data_o = word_i;
            MASK_BU: load_data_o = {24'h0, byte_sel};
            MASK_HU: load_data_o = {16'h0, half_sel};
            default: load_data_o = '0;
        endcase
    end

    always_comb begin
        store_word_o = word_i;
        case (mask_i)
            MASK_B: begin
                unique case (offset_i)
                    2'd0:    store_word_o[7:0]   = store_data_i[7:0];
                    2'd1:    store_word_o[15:8]  = store_data_i[7:0];
                    2'd2:    store_word_o[23:16] = store_data_i[7:0];
                    default: store_word_o[31:24] = store_data_i[7:0];
                endcase
            end
            MASK_H: begin
                if (offset_i[1]) store_word_o[31:16] = store_data_i[15:0];
                else             store_word_o[15:0]  = store_data_i[15:0];
            end
            MASK_W:  store_word_o = store_data_i;
            default: store_word_o = word_i;
        endcase
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller, one word per line.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   cpu_addr/wdata/mask   core request (byte address, store data, size/sign)
//   cpu_rd_en/wr_en       load/store request; both high is a store
//   cpu_rdata             extended load data (0 unless a load hits)
//   cpu_stall             core holds its request while high
//   mem_addr/wdata        word-aligned memory address, writeback data
//   mem_rd_en/wr_en       line fill / victim writeback request
//   mem_mask              always word
//   mem_rdata, mem_ready  fill data; completion of the current memory request
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter  int unsigned LINES   = 64,
    localparam int unsigned INDEX_W = $clog2(LINES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_mask,
    input  logic        cpu_rd_en,
    input  logic        cpu_wr_en,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [2:0]  mem_mask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    line_t              lines_q [LINES];
    state_e             state_q, state_d;
    logic [29:0]        miss_addr_q, miss_addr_d;

    logic [29:0]        req_waddr;
    logic [INDEX_W-1:0] req_idx, seq_idx;
    line_t              req_line, seq_line;
    logic               req_hit;
    logic               fill_en, store_en;
    logic [31:0]        load_data, store_word;

    assign req_waddr = cpu_addr[31:2];
    assign req_idx   = cpu_addr[INDEX_W+1:2];
    assign seq_idx   = miss_addr_q[INDEX_W-1:0];
    assign req_line  = lines_q[req_idx];
    assign seq_line  = lines_q[seq_idx];
    assign req_hit   = req_line.valid && (req_line.tag == req_waddr);
    assign mem_mask  = MASK_W;

    load_store_align u_align (
        .word_i       (req_line.data),
        .offset_i     (cpu_addr[1:0]),
        .mask_i       (cpu_mask),
        .store_data_i (cpu_wdata),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        cpu_stall   = 1'b0;
        cpu_rdata   = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_en     = 1'b0;
        store_en    = 1'b0;

        // Outputs are forced quiet while reset is held so nothing leaks to memory.
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_rd_en || cpu_wr_en) begin
                        if (req_hit) begin
                            if (cpu_wr_en) store_en  = 1'b1;
                            else           cpu_rdata = load_data;
                        end else begin
                            cpu_stall   = 1'b1;
                            miss_addr_d = req_waddr;
                            state_d     = (req_line.valid && req_line.dirty) ? StWriteback
                                                                             : StAllocate;
                        end
                    end
                end
                StWriteback: begin
                    cpu_stall = 1'b1;
                    mem_wr_en = 1'b1;
                    mem_addr  = {seq_line.tag, 2'b00};
                    mem_wdata = seq_line.data;
                    if (mem_ready) state_d = StAllocate;
                end
                StAllocate: begin
                    cpu_stall = 1'b1;
                    mem_rd_en = 1'b1;
                    mem_addr  = {miss_addr_q, 2'b00};
                    if (mem_ready) begin
                        fill_en = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Only valid/dirty are reset; stale tag/data are harmless once valid is clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(LINES); i++) begin
                lines_q[i].valid <= 1'b0;
                lines_q[i].dirty <= 1'b0;
            end
        end else if (fill_en) begin
            lines_q[seq_idx] <= '{valid: 1'b1, dirty: 1'b0, tag: miss_addr_q, data: mem_rdata};
        end else if (store_en) begin
            lines_q[req_idx].data  <= store_word;
            lines_q[req_idx].dirty <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus a randomized run checked
// against a behavioural cache/memory model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [2:0]  cpu_mask, mem_mask;
    logic        cpu_rd_en, cpu_wr_en, cpu_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd_en, mem_wr_en, mem_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dcache_ctrl #(.LINES(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_mask  (cpu_mask),
        .cpu_rd_en (cpu_rd_en),
        .cpu_wr_en (cpu_wr_en),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_mask  (mem_mask),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // Backing memory seen by the DUT, keyed by word address.
    logic [31:0] bmem [logic [29:0]];

    // Reference model: one-word lines, 64 of them, plus its own view of memory.
    logic        ref_valid [64];
    logic        ref_dirty [64];
    logic [29:0] ref_tag   [64];
    logic [31:0] ref_data  [64];
    logic [31:0] ref_mem   [logic [29:0]];

    typedef struct {
        int          stalls;
        int          nrd;
        int          nwr;
        logic [31:0] rdata;
        logic [31:0] rd_addr;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic        bad;
    } res_t;

    function automatic logic [31:0] def_word(logic [29:0] w);
        return ({2'b00, w} * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic logic [31:0] bmem_read(logic [29:0] w);
        return bmem.exists(w) ? bmem[w] : def_word(w);
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] off, logic [2:0] m);
        logic [31:0] b = (w >> (int'(off) * 8)) & 32'hFF;
        logic [31:0] h = (w >> (int'(off[1]) * 16)) & 32'hFFFF;
        case (m)
            3'b000:  return (b > 32'h7F) ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h > 32'h7FFF) ? (h | 32'hFFFF_0000) : h;
            3'b010:  return w;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_merge(logic [31:0] w, logic [31:0] d, logic [1:0] off,
                                              logic [2:0] m);
        int bs = int'(off) * 8;
        int hs = int'(off[1]) * 16;
        case (m)
            3'b000:  return (w & ~(32'hFF << bs)) | ((d & 32'hFF) << bs);
            3'b001:  return (w & ~(32'hFFFF << hs)) | ((d & 32'hFFFF) << hs);
            3'b010:  return d;
            default: return w;
        endcase
    endfunction

    task automatic model_req(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                             input logic [2:0] mask, output logic miss, output logic wb,
                             output logic [31:0] wb_addr, output logic [31:0] wb_data,
                             output logic [31:0] rdata);
        int          idx = int'(addr[7:2]);
        logic [29:0] wa  = addr[31:2];
        miss    = !(ref_valid[idx] && ref_tag[idx] == wa);
        wb      = miss && ref_valid[idx] && ref_dirty[idx];
        wb_addr = {ref_tag[idx], 2'b00};
        wb_data = ref_data[idx];
        if (wb) ref_mem[ref_tag[idx]] = ref_data[idx];
        if (miss) begin
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
            ref_tag[idx]   = wa;
            ref_data[idx]  = ref_mem.exists(wa) ? ref_mem[wa] : def_word(wa);
        end
        rdata = 32'h0;
        if (wr) begin
            ref_data[idx]  = ref_merge(ref_data[idx], wdata, addr[1:0], mask);
            ref_dirty[idx] = 1'b1;
        end else begin
            rdata = ref_load(ref_data[idx], addr[1:0], mask);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_mask = 3'b010;
        cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; mem_rdata = '0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
    endtask

    // Drives one request from posedge+1 until it completes (stall low), serving memory with
    // the given number of not-ready cycles on writeback and on allocate. Bounded to 64 cycles.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] mask,
                          input int low_wb, input int low_al, output res_t r);
        int wb_left = low_wb;
        int al_left = low_al;
        r = '{stalls: 0, nrd: 0, nwr: 0, rdata: '0, rd_addr: '0, wr_addr: '0, wr_data: '0,
              bad: 1'b0};
        cpu_addr = addr; cpu_wdata = wdata; cpu_mask = mask; cpu_rd_en = rd; cpu_wr_en = wr;
        for (int c = 0; c < 64; c++) begin
            #2;
            if ((mem_rd_en && mem_wr_en) || mem_mask !== 3'b010 || mem_addr[1:0] !== 2'b00)
                r.bad = 1'b1;
            if (!cpu_stall) begin
                r.rdata = cpu_rdata;
                break;
            end
            r.stalls++;
            mem_ready = 1'b1;
            if (mem_wr_en) begin
                if (r.nwr > 0 && mem_addr !== r.wr_addr) r.bad = 1'b1;
                r.nwr++; r.wr_addr = mem_addr; r.wr_data = mem_wdata;
                if (wb_left > 0) begin
                    mem_ready = 1'b0; wb_left--;
                end else begin
                    bmem[mem_addr[31:2]] = mem_wdata;
                end
            end
            if (mem_rd_en) begin
                if (r.nrd > 0 && mem_addr !== r.rd_addr) r.bad = 1'b1;
                r.nrd++; r.rd_addr = mem_addr;
                mem_rdata = bmem_read(mem_addr[31:2]);
                if (al_left > 0) begin
                    mem_ready = 1'b0; al_left--;
                end
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
        checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd_en); end
        checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr_en); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (mem_mask !== 3'b010) begin failures++; $display("FAIL reset_mem_mask got=%b exp=010", mem_mask); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_miss();
        res_t r;
        bmem[30'h40] = 32'hDEADBEEF;
        do_req(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0, 0, r);
        checks++; if (r.stalls !== 2) begin failures++; $display("FAIL lw_miss_stalls got=%0d exp=2", r.stalls); end
        checks++; if (r.nrd !== 1 || r.rd_addr !== 32'h100) begin failures++; $display("FAIL lw_miss_fill got=%0d@%h exp=1@00000100", r.nrd, r.rd_addr); end
        checks++; if (r.rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_miss_data got=%h exp=deadbeef", r.rdata); end
        do_req(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0, 0, r);
        checks++; if (r.stalls !== 0 || r.nrd !== 0) begin failures++; $display("FAIL lw_hit_stall got=%0d/%0d exp=0/0", r.stalls, r.nrd); end
        checks++; if (r.rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_hit_data got=%h exp=deadbeef", r.rdata); end
    endtask

    task automatic test_store_hit();
        res_t r;
        do_req(1'b0, 1'b1, 32'h100, 32'h11223344, 3'b010, 0, 0, r);
        do_req(1'b0, 1'b1, 32'h101, 32'h000000AA, 3'b000, 0, 0, r);
        checks++; if (r.stalls !== 0 || r.nwr !== 0) begin failures++; $display("FAIL sb_hit_traffic got=%0d/%0d exp=0/0", r.stalls, r.nwr); end
        checks++; if (r.rdata !== 32'h0) begin failures++; $display("FAIL sb_hit_rdata got=%h exp=0", r.rdata); end
        do_req(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0, 0, r);
        checks++; if (r.rdata !== 32'h1122AA44) begin failures++; $display("FAIL sb_merge got=%h exp=1122aa44", r.rdata); end
        do_req(1'b1, 1'b0, 32'h101, 32'h0, 3'b000, 0, 0, r);
        checks++; if (r.rdata !== 32'hFFFFFFAA) begin failures++; $display("FAIL lb got=%h exp=ffffffaa", r.rdata); end
        do_req(1'b1, 1'b0, 32'h101, 32'h0, 3'b100, 0, 0, r);
        checks++; if (r.rdata !== 32'h000000AA) begin failures++; $display("FAIL lbu got=%h exp=000000aa", r.rdata); end
        do_req(1'b1, 1'b0, 32'h100, 32'h0, 3'b011, 0, 0, r);
        checks++; if (r.rdata !== 32'h0) begin failures++; $display("FAIL bad_mask got=%h exp=0", r.rdata); end
    endtask

    task automatic test_dirty_miss();
        res_t r;
        bmem[30'h80] = 32'hCAFEF00D;
        do_req(1'b1, 1'b0, 32'h200, 32'h0, 3'b010, 0, 0, r);
        checks++; if (r.stalls !== 3) begin failures++; $display("FAIL dirty_stalls got=%0d exp=3", r.stalls); end
        checks++; if (r.nwr !== 1 || r.wr_addr !== 32'h100 || r.wr_data !== 32'h1122AA44) begin failures++; $display("FAIL dirty_wb got=%0d %h %h exp=1 00000100 1122aa44", r.nwr, r.wr_addr, r.wr_data); end
        checks++; if (r.nrd !== 1 || r.rd_addr !== 32'h200) begin failures++; $display("FAIL dirty_fill got=%0d@%h exp=1@00000200", r.nrd, r.rd_addr); end
        checks++; if (r.rdata !== 32'hCAFEF00D || r.bad) begin failures++; $display("FAIL dirty_data got=%h bad=%b exp=cafef00d bad=0", r.rdata, r.bad); end
    endtask

    task automatic test_wait_states();
        res_t r;
        bmem[30'h101] = 32'h0BADCAFE;
        do_req(1'b1, 1'b0, 32'h404, 32'h0, 3'b010, 0, 4, r);
        checks++; if (r.stalls !== 6) begin failures++; $display("FAIL wait_stalls got=%0d exp=6", r.stalls); end
        checks++; if (r.nrd !== 5 || r.rd_addr !== 32'h404 || r.bad) begin failures++; $display("FAIL wait_fill got=%0d@%h bad=%b exp=5@00000404 bad=0", r.nrd, r.rd_addr, r.bad); end
        checks++; if (r.rdata !== 32'h0BADCAFE) begin failures++; $display("FAIL wait_data got=%h exp=0badcafe", r.rdata); end
    endtask

    task automatic test_half_and_store_miss();
        res_t r;
        do_req(1'b0, 1'b1, 32'h104, 32'h80017FFF, 3'b010, 0, 0, r);
        checks++; if (r.stalls !== 2 || r.nwr !== 0) begin failures++; $display("FAIL sw_alloc got=%0d/%0d exp=2/0", r.stalls, r.nwr); end
        do_req(1'b1, 1'b0, 32'h106, 32'h0, 3'b001, 0, 0, r);
        checks++; if (r.rdata !== 32'hFFFF8001) begin failures++; $display("FAIL lh_hi got=%h exp=ffff8001", r.rdata); end
        do_req(1'b1, 1'b0, 32'h106, 32'h0, 3'b101, 0, 0, r);
        checks++; if (r.rdata !== 32'h00008001) begin failures++; $display("FAIL lhu_hi got=%h exp=00008001", r.rdata); end
        do_req(1'b1, 1'b0, 32'h104, 32'h0, 3'b001, 0, 0, r);
        checks++; if (r.rdata !== 32'h00007FFF) begin failures++; $display("FAIL lh_lo got=%h exp=00007fff", r.rdata); end
        do_req(1'b0, 1'b1, 32'h300, 32'h12345678, 3'b010, 0, 0, r);
        checks++; if (r.stalls !== 2 || r.nwr !== 0) begin failures++; $display("FAIL sw_miss got=%0d/%0d exp=2/0", r.stalls, r.nwr); end
        do_req(1'b1, 1'b0, 32'h300, 32'h0, 3'b010, 0, 0, r);
        checks++; if (r.rdata !== 32'h12345678 || r.stalls !== 0) begin failures++; $display("FAIL sw_miss_data got=%h/%0d exp=12345678/0", r.rdata, r.stalls); end
        do_req(1'b1, 1'b0, 32'h500, 32'h0, 3'b010, 0, 0, r);
        checks++; if (r.nwr !== 1 || r.wr_addr !== 32'h300 || r.wr_data !== 32'h12345678) begin failures++; $display("FAIL sw_miss_dirty got=%0d %h %h exp=1 00000300 12345678", r.nwr, r.wr_addr, r.wr_data); end
    endtask

    task automatic test_abandon();
        res_t r;
        int   waited = 0;
        cpu_addr = 32'h00C; cpu_mask = 3'b010; cpu_rd_en = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1 cpu_rd_en = 1'b0;
        while (waited < 10) begin
            #2;
            if (mem_rd_en) mem_rdata = bmem_read(mem_addr[31:2]);
            else if (!cpu_stall) break;
            waited++;
            @(posedge clk); #1;
        end
        if (!(waited < 10)) begin failures++; $display("FAIL abandon_timeout got=%0d exp=<10", waited); end
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 32'h00C, 32'h0, 3'b010, 0, 0, r);
        checks++; if (r.stalls !== 0 || r.rdata !== def_word(30'h3)) begin failures++; $display("FAIL abandon_fill got=%0d %h exp=0 %h", r.stalls, r.rdata, def_word(30'h3)); end
    endtask

    task automatic test_reset_mid();
        res_t r;
        do_req(1'b0, 1'b1, 32'h008, 32'h55667788, 3'b010, 0, 0, r);
        cpu_addr = 32'h108; cpu_mask = 3'b010; cpu_rd_en = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #2;
        checks++; if (mem_wr_en !== 1'b1) begin failures++; $display("FAIL mid_in_wb got=%b exp=1", mem_wr_en); end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; cpu_rd_en = 1'b0; mem_ready = 1'b1;
        #1;
        checks++; if (cpu_stall !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin failures++; $display("FAIL mid_quiet got=%b%b%b exp=000", cpu_stall, mem_wr_en, mem_rd_en); end
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0, 0, r);
        checks++; if (r.stalls !== 2 || r.nwr !== 0) begin failures++; $display("FAIL mid_remiss got=%0d/%0d exp=2/0", r.stalls, r.nwr); end
        checks++; if (bmem.exists(30'h2)) begin failures++; $display("FAIL mid_discard got=%h exp=absent", bmem[30'h2]); end
    endtask

    task automatic test_random();
        res_t        r;
        logic [31:0] addr, wdata, wb_addr, wb_data, exp_rd;
        logic [2:0]  mask;
        logic        rd, wr, miss, wb;
        int          lwb, lal, exp_st;
        logic [2:0]  ld_masks [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bmem.delete();
        ref_mem.delete();
        do_reset();
        for (int n = 0; n < 250; n++) begin
            addr  = (32'($urandom_range(1, 4)) << 8) | (32'($urandom_range(0, 3)) << 2)
                  | 32'($urandom_range(0, 3));
            wdata = $urandom;
            wr    = ($urandom_range(0, 1) == 1);
            rd    = !wr || ($urandom_range(0, 9) == 0);
            mask  = wr ? 3'($urandom_range(0, 2)) : ld_masks[$urandom_range(0, 4)];
            lwb   = $urandom_range(0, 2);
            lal   = $urandom_range(0, 2);
            model_req(addr, wr, wdata, mask, miss, wb, wb_addr, wb_data, exp_rd);
            exp_st = miss ? ((wb ? 3 + lwb : 2) + lal) : 0;
            do_req(rd, wr, addr, wdata, mask, lwb, lal, r);
            checks++; if (r.stalls !== exp_st) begin failures++; $display("FAIL rnd_stalls[%0d] got=%0d exp=%0d", n, r.stalls, exp_st); end
            checks++; if (r.bad) begin failures++; $display("FAIL rnd_protocol[%0d] got=1 exp=0", n); end
            if (!wr) begin
                checks++; if (r.rdata !== exp_rd) begin failures++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", n, r.rdata, exp_rd); end
            end
            if (miss) begin
                checks++; if (r.rd_addr !== {addr[31:2], 2'b00}) begin failures++; $display("FAIL rnd_fill_addr[%0d] got=%h exp=%h", n, r.rd_addr, {addr[31:2], 2'b00}); end
            end
            if (wb) begin
                checks++; if (r.wr_addr !== wb_addr || r.wr_data !== wb_data) begin failures++; $display("FAIL rnd_wb[%0d] got=%h:%h exp=%h:%h", n, r.wr_addr, r.wr_data, wb_addr, wb_data); end
            end else begin
                checks++; if (r.nwr !== 0) begin failures++; $display("FAIL rnd_no_wb[%0d] got=%0d exp=0", n, r.nwr); end
            end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_load_miss();
        test_store_hit();
        test_dirty_miss();
        test_wait_states();
        test_half_and_store_miss();
        test_abandon();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller.
- Sits between the core's load/store stage and the word-addressed data memory.
- Performs load extraction (byte/half/word, signed/unsigned) and store merging internally. All memory-side traffic is whole 32-bit words, so memory mask is always word.
- Stalls the core on a miss while it runs a writeback/allocate sequence.

Parameters:
- LINES, 64, number of one-word cache lines; power of two, at least 2.
- INDEX_W, $clog2(LINES), index width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  32  byte address from core
- cpu_wdata  in  32  store data; byte/half taken from low bits
- cpu_mask  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu; stores use 000/001/010 only
- cpu_rd_en  in  1  load request
- cpu_wr_en  in  1  store request
- cpu_rdata  out  32  extended load result
- cpu_stall  out  1  core must hold request stable while high
- mem_addr  out  32  word-aligned memory address (bits [1:0] = 0)
- mem_wdata  out  32  writeback data
- mem_rd_en  out  1  line fill request
- mem_wr_en  out  1  victim writeback request
- mem_mask  out  3  constant 3'b010
- mem_rdata  in  32  fill data
- mem_ready  in  1  memory completes the current mem_rd_en/mem_wr_en this cycle; tie high for single-cycle memory

Behaviour:
- Address split:
  - offset = addr[1:0]
  - index = addr[INDEX_W+1:2]
  - tag = addr[31:INDEX_W+2]
- Per-line state: valid, dirty, tag, 32-bit data.
- Reset:
  - All valid and dirty bits clear; FSM goes to IDLE.
  - cpu_stall=0, cpu_rdata=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
  - Dirty data present at reset is discarded with no writeback, including when reset lands mid-sequence.
- Request: a request is active when cpu_rd_en | cpu_wr_en. If both are high, the request is treated as a store.
- Hit = valid[index] & (tag match), evaluated combinationally in IDLE.
- Load hit:
  - cpu_rdata is valid in the same cycle; cpu_stall=0.
  - Extraction: byte by offset, half by addr[1], word ignores offset.
  - Sign extension per mask; an unknown mask returns 0.
  - When no load is active, cpu_rdata=0.
- Store hit:
  - The merged word is written to the line at posedge; dirty is set; cpu_stall=0.
  - Merge: byte lane selected by offset, half lane by addr[1].
  - No memory traffic.
- FSM states:
  - IDLE: no stall.
    - Miss with a dirty victim: cpu_stall=1, go to WRITEBACK.
    - Miss with a clean or invalid victim: cpu_stall=1, go to ALLOCATE.
    - The miss word address is latched into a register that drives mem_addr during the sequence.
  - WRITEBACK:
    - mem_wr_en=1, mem_addr={victim tag, index, 2'b00}, mem_wdata=victim data, cpu_stall=1.
    - On mem_ready, go to ALLOCATE. Otherwise hold all outputs.
  - ALLOCATE:
    - mem_rd_en=1, mem_addr={latched miss address[31:2], 2'b00}, cpu_stall=1.
    - On mem_ready: data<=mem_rdata, tag updated, valid=1, dirty=0, go to IDLE.
    - Otherwise hold.
  - IDLE after refill: the held request now hits and completes with stall=0. A store completes with write-allocate and the merge applied at that point.
- Latency with mem_ready tied high:
  - hit: 0 stall cycles
  - clean miss: 2 stall cycles
  - dirty miss: 3 stall cycles
  - Each cycle mem_ready is low adds one stall cycle.
- mem_rd_en and mem_wr_en are never high together.
- Request deasserted during a stall: the sequence still completes (line filled), then the FSM returns to IDLE.

Decomposition:
- dcache_pkg:
  - mask encodings (MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU)
  - FSM state enum (IDLE, WRITEBACK, ALLOCATE)
  - the line struct (valid, dirty, tag, data)
- Sub-module load_store_align, purely combinational: load extract (word, offset, mask -> rdata) and store merge (old word, wdata, offset, mask -> new word).

Test Plan:
1. After reset, lw 0x100 with mem_rdata=0xDEADBEEF and mem_ready=1 -> stall for 2 cycles, mem_rd_en once at mem_addr 0x100, then cpu_rdata=0xDEADBEEF. A repeat lw 0x100 gives stall=0 and no mem_rd_en.
2. Line 0x100 holds 0x11223344; sb 0x101 with wdata 0x000000AA -> line becomes 0x1122AA44, no mem_wr_en. Then lb 0x101 -> 0xFFFFFFAA; lbu 0x101 -> 0x000000AA.
3. With 0x100 dirty (0x1122AA44), lw 0x200 (same index 0) -> mem_wr_en at 0x100 with wdata 0x1122AA44, then mem_rd_en at 0x200, 3 stall cycles, then mem_rdata is returned.
4. Clean miss with mem_ready low for 4 cycles in ALLOCATE -> stall for 6 cycles total, mem_rd_en and mem_addr stable throughout, and no line update before mem_ready.
5. Line 0x104 holds 0x8001_7FFF; lh 0x106 -> 0xFFFF8001, lhu 0x106 -> 0x00008001, lh 0x104 -> 0x00007FFF. Then sw miss at 0x300 -> allocate, then merge, line dirty, no write to memory.
6. Reset asserted during WRITEBACK -> next cycle stall=0, mem_wr_en=0, mem_rd_en=0, and lw 0x100 misses again.
